// File: rtl/perf_stat_pkg.sv
// Shared types and constants for the performance-statistics / syscall-monitor block.
package perf_stat_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [31:0] HALT_CODE_DEF = 32'd10;
   localparam logic [31:0] SHOW_CODE_DEF = 32'd34;

   localparam int EV_CYCLE      = 0;
   localparam int EV_UNCOND     = 1;
   localparam int EV_COND       = 2;
   localparam int EV_COND_TAKEN = 3;

   // Select width for an n-entry bank; a single entry still gets a 1-bit index.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stat_fifo.sv
// Width x depth synchronous FIFO with ready/valid head and push-while-full-with-pop support.
module stat_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pop;
   logic          do_push;

   assign valid   = (count != '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop     = valid && ready;
   assign do_push = push && (!full || pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; the head is masked while empty so stale words never escape.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/perf_stat_unit.sv
// Retire-qualified event counters with snapshot bank, halt syscall FSM and display-syscall queue.
module perf_stat_unit
   import perf_stat_pkg::*;
#(
   parameter int          NUM_EV     = 4,
   parameter int          CNT_W      = 32,
   parameter bit          SATURATE   = 1'b0,
   parameter int          SHOW_DEPTH = 4,
   parameter logic [31:0] HALT_CODE  = HALT_CODE_DEF,
   parameter logic [31:0] SHOW_CODE  = SHOW_CODE_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [NUM_EV-1:0]         ev,
   input  logic                      syscall_t,
   input  logic [31:0]               A,
   input  logic [31:0]               B,
   input  logic                      clr,
   input  logic                      snap,
   input  logic [sel_w(NUM_EV)-1:0]  rd_sel,
   output logic [CNT_W-1:0]          rd_data,
   output logic [NUM_EV*CNT_W-1:0]   cnt_flat,
   output logic [NUM_EV-1:0]         ovf,
   output logic                      halt,
   input  logic                      resume,
   output logic [31:0]               out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      show_drop
);

   localparam int SEL_W  = sel_w(NUM_EV);
   localparam int BANK_N = 1 << SEL_W;

   state_t state_q, state_d;
   logic   act;
   logic   is_halt;
   logic   is_show;
   logic   pop;
   logic   fifo_full;

   assign act     = en && (state_q == RUN);
   assign is_halt = act && syscall_t && (A == HALT_CODE);
   assign is_show = act && syscall_t && (A == SHOW_CODE);
   assign pop     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // NOTE: next state defaults to the current state first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:    if (is_halt) state_d = HALTED;
         HALTED: if (resume)  state_d = RUN;
      endcase
   end

   assign halt = (state_q == HALTED);

   logic [CNT_W-1:0] snap_word [BANK_N];

   for (genvar i = 0; i < NUM_EV; i++) begin : g_ev
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] snap_q;
      logic             ovf_q;

      always_ff @(posedge clk) begin
         if (rst || clr) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else if (act && ev[i]) begin
            if (&cnt_q) begin
               cnt_q <= SATURATE ? cnt_q : '0;
               ovf_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end

      // Captures the registered value, so snap alongside clr keeps the pre-clear count.
      always_ff @(posedge clk) begin
         if (rst)       snap_q <= '0;
         else if (snap) snap_q <= cnt_q;
      end

      assign snap_word[i]                  = snap_q;
      assign cnt_flat[i*CNT_W +: CNT_W]    = cnt_q;
      assign ovf[i]                        = ovf_q;
   end

   // Unused select codes read as zero.
   for (genvar j = NUM_EV; j < BANK_N; j++) begin : g_pad
      assign snap_word[j] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= snap_word[rd_sel];
   end

   stat_fifo #(
      .W     (32),
      .DEPTH (SHOW_DEPTH)
   ) u_show_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (is_show),
      .push_data (B),
      .ready     (out_ready),
      .valid     (out_valid),
      .data      (out_data),
      .full      (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (rst)                               show_drop <= 1'b0;
      else if (is_show && fifo_full && !pop) show_drop <= 1'b1;
   end

endmodule

// File: tb/tb_perf_stat_unit.sv
// Scoreboard bench: wrapping and saturating 8-bit instances against an event-count reference model.
module tb_perf_stat_unit;

   localparam int NUM_EV = 4;
   localparam int CNT_W  = 8;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst, en, syscall_t, clr, snap, resume, out_ready;
   logic [3:0]  ev;
   logic [31:0] a, b;
   logic [1:0]  rd_sel;

   logic [7:0]  rd_data_w, rd_data_s;
   logic [31:0] cnt_flat_w, cnt_flat_s;
   logic [3:0]  ovf_w, ovf_s;
   logic        halt_w, halt_s;
   logic [31:0] out_data_w, out_data_s;
   logic        out_valid_w, out_valid_s;
   logic        show_drop_w, show_drop_s;

   always #5 clk = ~clk;

   perf_stat_unit #(.NUM_EV(NUM_EV), .CNT_W(CNT_W), .SATURATE(1'b0), .SHOW_DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .ev(ev), .syscall_t(syscall_t), .A(a), .B(b),
      .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_data(rd_data_w), .cnt_flat(cnt_flat_w),
      .ovf(ovf_w), .halt(halt_w), .resume(resume), .out_data(out_data_w),
      .out_valid(out_valid_w), .out_ready(out_ready), .show_drop(show_drop_w)
   );

   perf_stat_unit #(.NUM_EV(NUM_EV), .CNT_W(CNT_W), .SATURATE(1'b1), .SHOW_DEPTH(DEPTH)) u_sat (
      .clk(clk), .rst(rst), .en(en), .ev(ev), .syscall_t(syscall_t), .A(a), .B(b),
      .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_data(rd_data_s), .cnt_flat(cnt_flat_s),
      .ovf(ovf_s), .halt(halt_s), .resume(resume), .out_data(out_data_s),
      .out_valid(out_valid_s), .out_ready(out_ready), .show_drop(show_drop_s)
   );

   // Reference model: events counted since the last clear, rendered per mode arithmetically.
   int          m_n [NUM_EV];
   logic [7:0]  m_bank_w [NUM_EV];
   logic [7:0]  m_bank_s [NUM_EV];
   logic [7:0]  m_rd_w, m_rd_s;
   bit          m_halt, m_drop;
   logic [31:0] exp_q [$];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [7:0] wrap_val(input int n);
      return 8'(n % 256);
   endfunction

   function automatic logic [7:0] sat_val(input int n);
      return (n > 255) ? 8'd255 : 8'(n);
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      n_cmp++;
      if (actual !== required) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, actual, required);
      end
   endtask

   task automatic model_edge();
      bit act_m;
      bit pop_m;
      int occ;
      if (rst) begin
         for (int i = 0; i < NUM_EV; i++) begin
            m_n[i] = 0; m_bank_w[i] = '0; m_bank_s[i] = '0;
         end
         m_rd_w = '0; m_rd_s = '0; m_halt = 0; m_drop = 0;
         exp_q.delete();
      end else begin
         act_m = en && !m_halt;
         occ   = exp_q.size();
         pop_m = (occ > 0) && out_ready;
         m_rd_w = m_bank_w[rd_sel];
         m_rd_s = m_bank_s[rd_sel];
         if (snap)
            for (int i = 0; i < NUM_EV; i++) begin
               m_bank_w[i] = wrap_val(m_n[i]);
               m_bank_s[i] = sat_val(m_n[i]);
            end
         for (int i = 0; i < NUM_EV; i++)
            if (clr) m_n[i] = 0;
            else if (act_m && ev[i]) m_n[i]++;
         if (m_halt) begin
            if (resume) m_halt = 0;
         end else if (act_m && syscall_t && a == 32'd10) begin
            m_halt = 1;
         end
         if (act_m && syscall_t && a == 32'd34) begin
            if (occ < DEPTH || pop_m) exp_q.push_back(b);
            else m_drop = 1;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NUM_EV; i++) begin
         check($sformatf("cnt_wrap[%0d]", i), cnt_flat_w[i*8 +: 8], wrap_val(m_n[i]));
         check($sformatf("cnt_sat[%0d]", i),  cnt_flat_s[i*8 +: 8], sat_val(m_n[i]));
         check($sformatf("ovf_wrap[%0d]", i), ovf_w[i], m_n[i] > 255);
         check($sformatf("ovf_sat[%0d]", i),  ovf_s[i], m_n[i] > 255);
      end
      check("halt_wrap", halt_w, m_halt);
      check("halt_sat", halt_s, m_halt);
      check("out_valid", out_valid_w, exp_q.size() > 0);
      if (exp_q.size() > 0) check("out_head", out_data_w, exp_q[0]);
      check("show_drop", show_drop_w, m_drop);
      check("rd_data_wrap", rd_data_w, m_rd_w);
      check("rd_data_sat", rd_data_s, m_rd_s);
   endtask

   task automatic idle();
      rst = 0; en = 0; ev = '0; syscall_t = 0; a = '0; b = '0;
      clr = 0; snap = 0; resume = 0; rd_sel = '0; out_ready = 1;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic show(input logic [31:0] val);
      en = 1; syscall_t = 1; a = 32'd34; b = val;
      tick();
   endtask

   // Monitor: every handshake the DUT completes on the next edge must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid_w && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_unexpected: got %0h required no entry", out_data_w);
         end else begin
            check("pop_data", out_data_w, exp_q.pop_front());
         end
      end
   end

   initial begin
      idle();
      rst = 1;
      repeat (3) tick();
      rst = 0;

      en = 1; ev = 4'b0001;
      repeat (10) tick();

      ev = 4'b0010;
      repeat (257) tick();
      idle(); clr = 1; tick(); clr = 0;

      en = 1; ev = 4'b0001;
      repeat (5) tick();
      snap = 1; clr = 1; tick();
      idle();
      repeat (2) tick();

      en = 1; ev = 4'b0001; syscall_t = 1; a = 32'd10;
      tick();
      syscall_t = 0; ev = 4'b1111;
      repeat (3) tick();
      show(32'h55);
      idle(); en = 1; ev = 4'b1111; resume = 1; tick();
      resume = 0;
      repeat (3) tick();

      idle(); out_ready = 0;
      for (int k = 1; k <= 5; k++) show(32'(k));
      idle();
      repeat (6) tick();

      rst = 1; tick(); idle();
      out_ready = 0;
      for (int k = 11; k <= 14; k++) show(32'(k));
      out_ready = 1; show(32'd9);
      idle();
      repeat (6) tick();

      for (int k = 0; k < 600; k++) begin
         rst       = (k == 300);
         en        = ($urandom_range(0, 3) != 0);
         ev        = 4'($urandom);
         syscall_t = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 2))
            0:       a = 32'd10;
            1:       a = 32'd34;
            default: a = $urandom;
         endcase
         b         = $urandom;
         clr       = ($urandom_range(0, 99) == 0);
         snap      = ($urandom_range(0, 7) == 0);
         rd_sel    = 2'($urandom);
         resume    = ($urandom_range(0, 4) == 0);
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end

      idle();
      repeat (6) tick();
      check("drain_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/perf_stat_unit.md
# perf_stat_unit

Parametrised performance-statistics and syscall-monitor block for the MIPS core. Counts `NUM_EV` retire-qualified events into independent counters with wrap or saturate mode, sticky overflow flags, and a snapshot bank with a registered read port. Decodes the halt syscall into a sticky halt state machine with a resume path. Queues display-syscall payloads in a small ready/valid FIFO for the board display / testbench sink. Sits beside the writeback stage and takes the same syscall operands and retire enable as the rest of the datapath.

## Interface
Parameters:
- `NUM_EV`, default 4: number of event counters, 1..16.
- `CNT_W`, default 32: counter width, 8..32.
- `SATURATE`, default 0: 0 means counters wrap; 1 means counters stick at all-ones.
- `SHOW_DEPTH`, default 4: display FIFO depth, power of two, 2..16.
- `HALT_CODE`, default 10: `A` value that halts.
- `SHOW_CODE`, default 34: `A` value that pushes `B` to the display FIFO.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `en`, in, 1: instruction retires this cycle; qualifies all events and syscalls.
- `ev`, in, `NUM_EV`: per-counter event strobes. Bit 0 is cycles, 1 is unconditional branch, 2 is conditional branch, 3 is conditional branch taken.
- `syscall_t`, in, 1: retiring instruction is a syscall.
- `A`, in, 32: syscall code.
- `B`, in, 32: syscall argument.
- `clr`, in, 1: zero all counters and overflow flags.
- `snap`, in, 1: copy all live counters into the snapshot bank.
- `rd_sel`, in, `$clog2(NUM_EV)` (minimum 1): snapshot read index.
- `rd_data`, out, `CNT_W`: registered snapshot word.
- `cnt_flat`, out, `NUM_EV*CNT_W`: live counters; counter i occupies bits [i*CNT_W +: CNT_W].
- `ovf`, out, `NUM_EV`: sticky overflow flags.
- `halt`, out, 1: high while in state HALTED.
- `resume`, in, 1: leave HALTED.
- `out_data`, out, 32: display FIFO head.
- `out_valid`, out, 1: FIFO non-empty.
- `out_ready`, in, 1: sink accepts the head.
- `show_drop`, out, 1: sticky flag; a display push was lost because the FIFO was full.

## Operation
- Let `act = en && state==RUN`.
- Counter i increments when `act && ev[i]`.
  - At all-ones: wrap to 0 (`SATURATE=0`) or hold all-ones (`SATURATE=1`). In both modes set `ovf[i]`.
- `clr` has priority over increment: counters and `ovf` are 0 on the next cycle, and events in the `clr` cycle are lost.
- `snap` copies the pre-increment (current registered) values of all counters. `snap` with `clr` in the same cycle captures the pre-clear values.
- Halt FSM has two states, RUN and HALTED:
  - RUN to HALTED when `act && syscall_t && A==HALT_CODE`. Events in that same cycle are still counted.
  - HALTED to RUN when `resume`.
  - In HALTED, counting and syscall decode are suppressed. `clr`, `snap`, reads and FIFO pops still work.
  - `resume` in RUN has no effect.
- Display push condition: `act && syscall_t && A==SHOW_CODE`, data is `B`.
  - Push when full with no pop in the same cycle: drop the value and set `show_drop`.
  - Push while full with a pop in the same cycle: both occur and occupancy is unchanged.
- Pop condition: `out_valid && out_ready`.
- `show_drop` clears only on `rst`.
- Other `A` codes are ignored.

## Timing
- Reset values: all counters 0, `ovf` 0, snapshot bank 0, `rd_data` 0, `halt` 0, state RUN, FIFO empty (`out_valid` 0, `out_data` 0), `show_drop` 0.
- Counter update: visible on `cnt_flat` one cycle after the event.
- Snapshot: bank valid the cycle after `snap`. `rd_data` equals `snapshot[rd_sel]` one cycle after `rd_sel` is presented, so `snap` to `rd_data` is 2 cycles. Out-of-range `rd_sel` returns 0.
- Halt: `halt` rises the cycle after the halt syscall and falls the cycle after `resume`.
- FIFO: push to `out_valid` high is 1 cycle. A push into an empty FIFO with `out_ready` high is not bypassed. `out_data` is stable while `out_valid && !out_ready`.
- FIFO pointers are `$clog2(SHOW_DEPTH)` bits and wrap naturally. Occupancy is one bit wider.
- `rst` mid-operation: all state returns to reset values on the next edge, and queued FIFO entries are discarded.

## Structure
- Package `perf_stat_pkg` holds:
  - the state enum (RUN, HALTED);
  - `HALT_CODE_DEF`=10 and `SHOW_CODE_DEF`=34;
  - the event index constants EV_CYCLE=0, EV_UNCOND=1, EV_COND=2, EV_COND_TAKEN=3.
- Sub-module `stat_fifo`: a parametrised width×depth synchronous FIFO with ready/valid output, `full` output and push/pop-same-cycle handling. The display queue instantiates it.
- Counters and the snapshot bank live in a generate loop over `NUM_EV`.

## Test plan
- Reset, then `en`=1 and `ev`=4'b0001 for 10 cycles -> `cnt_flat[31:0]`=10, other counters 0, `ovf`=0.
- `CNT_W`=8, `SATURATE`=0, 257 increments of ev[1] -> counter 1 = 1, `ovf[1]`=1. With `SATURATE`=1 -> counter 1 = 255, `ovf[1]`=1.
- Counter 0 = 5, assert `snap`+`clr` together, then `rd_sel`=0 -> `rd_data`=5 two cycles later, `cnt_flat[7:0]`=0.
- Syscall `A`=10 with ev[0] in the same cycle -> counter 0 incremented, `halt`=1 next cycle, further events ignored. `resume` -> `halt`=0, counting resumes.
- `out_ready`=0, five `A`=34 syscalls with `B`=1..5 -> FIFO holds 1..4, `show_drop`=1. Then `out_ready`=1 -> pops 1,2,3,4 on consecutive cycles, then `out_valid`=0.
- Full FIFO with `out_ready`=1 and a push of `B`=9 in the same cycle -> no drop, 9 emerges after the three older entries.
